// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence-detector path: serializer state
// encodings and the default word width.
package seq_pkg;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'b00,
        SER_SHIFT  = 2'b01,
        SER_PARITY = 2'b10
    } ser_state_e;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end feeding the sequence detector's din, one bit per clk.
// Define SER_PARITY_EN to append an even-parity bit after each word.
//
// state      | meaning
// SER_IDLE   | no word in flight, dout = IDLE_BIT, ready for a word
// SER_SHIFT  | data bit cnt_q of the current word is on dout
// SER_PARITY | parity bit of the current word is on dout (SER_PARITY_EN only)
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = SER_WIDTH_DEFAULT,
    parameter logic IDLE_BIT  = 1'b0,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    ser_state_e       state_q;
    ser_state_e       state_d;
    logic             ready_c;
    logic             accept;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
`ifdef SER_PARITY_EN
    logic             par_q;
`endif

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        case (state_q)
            SER_IDLE: begin
                ready_c = 1'b1;
                if (s_valid) state_d = SER_SHIFT;
            end
            SER_SHIFT: begin
                if (cnt_q == LAST) begin
`ifdef SER_PARITY_EN
                    state_d = SER_PARITY;
`else
                    // final data bit doubles as the reload slot for gapless streaming
                    ready_c = 1'b1;
                    state_d = s_valid ? SER_SHIFT : SER_IDLE;
`endif
                end
            end
`ifdef SER_PARITY_EN
            SER_PARITY: begin
                ready_c = 1'b1;
                state_d = s_valid ? SER_SHIFT : SER_IDLE;
            end
`endif
            default: state_d = SER_IDLE;
        endcase
    end

    assign s_ready = ready_c && !rst;
    assign accept  = s_valid && s_ready;
    assign busy    = (state_q != SER_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= SER_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= IDLE_BIT;
            dout_valid <= 1'b0;
            word_done  <= 1'b0;
            cnt_q      <= '0;
            shreg_q    <= '0;
`ifdef SER_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            word_done <= 1'b0;
            if (accept) begin
                // first bit goes straight to dout; shreg keeps the remainder
                dout       <= MSB_FIRST ? s_data[WIDTH-1] : s_data[0];
                shreg_q    <= MSB_FIRST ? {s_data[WIDTH-2:0], 1'b0}
                                        : {1'b0, s_data[WIDTH-1:1]};
                dout_valid <= 1'b1;
                cnt_q      <= '0;
`ifdef SER_PARITY_EN
                par_q      <= ^s_data;
`endif
            end else if (state_q == SER_SHIFT && cnt_q != LAST) begin
                dout       <= MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
                shreg_q    <= MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shreg_q[WIDTH-1:1]};
                dout_valid <= 1'b1;
                cnt_q      <= cnt_q + CW'(1);
`ifndef SER_PARITY_EN
                word_done  <= (cnt_q == PENULT);
`endif
            end else if (state_q == SER_SHIFT) begin
`ifdef SER_PARITY_EN
                dout       <= par_q;
                dout_valid <= 1'b1;
                word_done  <= 1'b1;
`else
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
`endif
                cnt_q      <= '0;
            end else begin
                dout       <= IDLE_BIT;
                dout_valid <= 1'b0;
                cnt_q      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: MSB-first and LSB-first instances share stimulus.
module tb_seq_bit_serializer;

    typedef struct packed {
        logic d;
        logic done;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;

    logic s_ready0, dout0, dout_valid0, word_done0, busy0;
    logic s_ready1, dout1, dout_valid1, word_done1, busy1;

    beat_t q0[$];
    beat_t q1[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
        .dout(dout0), .dout_valid(dout_valid0), .word_done(word_done0), .busy(busy0)
    );

    seq_bit_serializer #(.WIDTH(8), .IDLE_BIT(1'b0), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
        .dout(dout1), .dout_valid(dout_valid1), .word_done(word_done1), .busy(busy1)
    );

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word becomes a list of bits on the wire, last one flagged done.
    task automatic push_word(input logic [7:0] w);
        beat_t b;
        for (int i = 0; i < 8; i++) begin
            b.done = (i == 7);
`ifdef SER_PARITY_EN
            b.done = 1'b0;
`endif
            b.d = w[7-i];
            q0.push_back(b);
            b.d = w[i];
            q1.push_back(b);
        end
`ifdef SER_PARITY_EN
        b.d    = ^w;
        b.done = 1'b1;
        q0.push_back(b);
        q1.push_back(b);
`endif
    endtask

    // Ready exactly when nothing remains beyond the bit currently on the wire.
    task automatic cycle(input logic v, input logic [7:0] d, output bit acc);
        @(negedge clk);
        #1;
        s_valid = v;
        s_data  = d;
        acc = v && !rst && (q0.size() == 0);
        if (acc) push_word(d);
    endtask

    task automatic send(input logic [7:0] w);
        bit acc;
        int n;
        n = 0;
        do begin
            cycle(1'b1, w, acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %h not accepted after %0d cycles", w, n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, acc);
    endtask

    initial begin
        beat_t b;
        logic  ev;
        @(posedge clk);
        forever begin
            @(negedge clk);
            ev = (q0.size() > 0);
            check("dout_valid_msb", dout_valid0, ev);
            check("busy_msb", busy0, ev);
            if (ev) begin
                b = q0.pop_front();
                check("dout_msb", dout0, b.d);
                check("word_done_msb", word_done0, b.done);
            end else begin
                check("idle_dout_msb", dout0, 1'b0);
                check("idle_word_done_msb", word_done0, 1'b0);
            end
            ev = (q1.size() > 0);
            check("dout_valid_lsb", dout_valid1, ev);
            check("busy_lsb", busy1, ev);
            if (ev) begin
                b = q1.pop_front();
                check("dout_lsb", dout1, b.d);
                check("word_done_lsb", word_done1, b.done);
            end else begin
                check("idle_dout_lsb", dout1, 1'b0);
                check("idle_word_done_lsb", word_done1, 1'b0);
            end
            check("s_ready_msb", s_ready0, !rst && q0.size() == 0);
            check("s_ready_lsb", s_ready1, !rst && q1.size() == 0);
        end
    end

    initial begin
        bit         acc;
        bit         hold;
        logic       v;
        logic [7:0] cur;

        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        idle(20);
        send(8'hD0);
        idle(10);
        send(8'hA5);
        send(8'h3C);
        idle(20);
        send(8'h0B);
        idle(12);

        // reset lands while the third bit of 8'hFF is on the wire
        send(8'hFF);
        idle(2);
        @(negedge clk);
        #1;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h55;
        q0.delete();
        q1.delete();
        cycle(1'b1, 8'h55, acc);
        cycle(1'b1, 8'h55, acc);
        @(negedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        idle(5);

        send(8'h07);
        send(8'h03);
        idle(20);

        hold = 1'b0;
        v    = 1'b0;
        cur  = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                v   = ($urandom_range(0, 9) < 7);
                cur = 8'($urandom);
            end
            cycle(v, cur, acc);
            hold = v && !acc;
        end
        idle(30);

        check("drain_msb", q0.size() == 0, 1'b1);
        check("drain_lsb", q1.size() == 0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
